// File: rtl/microc_pkg.sv
// Shared constants for the microc_call datapath: ALU operation codes and
// instruction field widths.
package microc_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 6;
    localparam int IMM_W    = 8;
    localparam int RF_AW    = 4;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_NOT  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_NEGA = 3'b110,
        OP_NEGB = 3'b111
    } alu_op_e;

endpackage

// File: rtl/microc_call_if.sv
// Bundle between the control unit / program ROM (master) and the
// microc_call datapath (slave).
interface microc_call_if #(
    parameter int PC_W = 10
) ();
    import microc_pkg::*;

    logic [INSTR_W-1:0]  instr;
    logic                s_inc;
    logic                s_inm;
    logic                we3;
    logic                wez;
    logic                wec;
    logic [2:0]          Op;
    logic                push;
    logic                pop;
    logic [PC_W-1:0]     pc;
    logic [OPCODE_W-1:0] Opcode;
    logic                z;
    logic                c;
    logic                stk_ovf;
    logic                stk_unf;

    modport master (
        output instr, s_inc, s_inm, we3, wez, wec, Op, push, pop,
        input  pc, Opcode, z, c, stk_ovf, stk_unf
    );

    modport slave (
        input  instr, s_inc, s_inm, we3, wez, wec, Op, push, pop,
        output pc, Opcode, z, c, stk_ovf, stk_unf
    );

endinterface

// File: rtl/microc_call_ret_stack.sv
// Hardware return-address stack: STK_DEPTH entries, sp counts occupied
// entries, sticky overflow/underflow flags cleared only by reset.
module ret_stack #(
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf
);

    localparam int         AW      = $clog2(STK_DEPTH);
    localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] SP_FULL = (AW+1)'(STK_DEPTH);

    logic [PC_W-1:0] mem_r [STK_DEPTH];
    logic [AW:0]     sp_r;
    logic [AW-1:0]   top_idx_s;
    logic            do_push_s;
    logic            do_pop_s;
    logic            ovf_r;
    logic            unf_r;

    // Occupancy decode and push/pop qualification; simultaneous push+pop is a no-op.
    always_comb begin
        full      = (sp_r == SP_FULL);
        empty     = (sp_r == {(AW+1){1'b0}});
        top_idx_s = sp_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
        dout      = mem_r[top_idx_s];
        do_push_s = push && !pop && !full;
        do_pop_s  = pop && !push && !empty;
    end

    // Stack pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_r <= {(AW+1){1'b0}};
        end else if (do_push_s) begin
            sp_r <= sp_r + SP_ONE;
        end else if (do_pop_s) begin
            sp_r <= sp_r - SP_ONE;
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (push && !pop && full) begin
                ovf_r <= 1'b1;
            end
            if (pop && !push && empty) begin
                unf_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[sp_r[AW-1:0]] <= din;
        end
    end

    assign ovf = ovf_r;
    assign unf = unf_r;

endmodule

// File: rtl/microc_call.sv
// Single-cycle microcontroller datapath: PC, 16-entry register file, ALU,
// zero/carry flags and a return-address stack for CALL/RET.
module microc_call
    import microc_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int DATA_W    = 8,
    parameter int STK_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    microc_call_if.slave bus
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] rf_r [16];
    logic [RF_AW-1:0]  ra1_s;
    logic [RF_AW-1:0]  ra2_s;
    logic [RF_AW-1:0]  wa3_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] result_s;
    logic              z_next_s;
    logic              c_next_s;
    logic              z_r;
    logic              c_r;

    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   pc_seq_s;
    logic [PC_W-1:0]   pc_next_s;
    logic [PC_W-1:0]   stk_dout_s;
    logic              stk_full_unused_s;
    logic              stk_empty_s;
    logic              stk_ovf_s;
    logic              stk_unf_s;

    // Register-file read ports and operand selection; R0 is hardwired to zero.
    always_comb begin
        ra1_s = bus.instr[11:8];
        ra2_s = bus.s_inm ? bus.instr[3:0] : bus.instr[7:4];
        wa3_s = bus.instr[3:0];
        rd1_s = (ra1_s == 4'd0) ? {DATA_W{1'b0}} : rf_r[ra1_s];
        rd2_s = (ra2_s == 4'd0) ? {DATA_W{1'b0}} : rf_r[ra2_s];
        a_s   = bus.s_inm ? DATA_W'(bus.instr[11:4]) : rd1_s;
        b_s   = rd2_s;
    end

    // ALU; carry is the adder carry-out for ADD and the unsigned borrow for SUB.
    always_comb begin
        sum_s    = {1'b0, a_s} + {1'b0, b_s};
        result_s = a_s;
        c_next_s = 1'b0;
        case (alu_op_e'(bus.Op))
            OP_MOV:  result_s = a_s;
            OP_NOT:  result_s = ~a_s;
            OP_ADD: begin
                result_s = sum_s[DATA_W-1:0];
                c_next_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                result_s = a_s - b_s;
                c_next_s = (a_s < b_s);
            end
            OP_AND:  result_s = a_s & b_s;
            OP_OR:   result_s = a_s | b_s;
            OP_NEGA: result_s = {DATA_W{1'b0}} - a_s;
            OP_NEGB: result_s = {DATA_W{1'b0}} - b_s;
            default: result_s = a_s;
        endcase
        z_next_s = (result_s == {DATA_W{1'b0}});
    end

    // Register-file write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (bus.we3 && (wa3_s != 4'd0)) begin
            rf_r[wa3_s] <= result_s;
        end
    end

    // Zero and carry flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_r <= 1'b0;
            c_r <= 1'b0;
        end else begin
            if (bus.wez) begin
                z_r <= z_next_s;
            end
            if (bus.wec) begin
                c_r <= c_next_s;
            end
        end
    end

    // Next-PC selection: a lone pop returns (or steps past an empty stack), otherwise s_inc decides.
    always_comb begin
        pc_inc_s = pc_r + PC_ONE;
        pc_seq_s = bus.s_inc ? pc_inc_s : bus.instr[PC_W-1:0];
        if (bus.pop && !bus.push) begin
            pc_next_s = stk_empty_s ? pc_inc_s : stk_dout_s;
        end else begin
            pc_next_s = pc_seq_s;
        end
    end

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= {PC_W{1'b0}};
        end else begin
            pc_r <= pc_next_s;
        end
    end

    ret_stack #(
        .PC_W      (PC_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (bus.push),
        .pop   (bus.pop),
        .din   (pc_inc_s),
        .dout  (stk_dout_s),
        .full  (stk_full_unused_s),
        .empty (stk_empty_s),
        .ovf   (stk_ovf_s),
        .unf   (stk_unf_s)
    );

    assign bus.pc      = pc_r;
    assign bus.Opcode  = bus.instr[15:10];
    assign bus.z       = z_r;
    assign bus.c       = c_r;
    assign bus.stk_ovf = stk_ovf_s;
    assign bus.stk_unf = stk_unf_s;

endmodule
